// File: rtl/seq_divider_n.sv
// seq_divider_n: iterative unsigned restoring divider with valid/ready handshakes.
// One shared (nb_bit+1)-bit subtractor_n, one quotient bit per cycle, MSB first.
// Optional macro DIV_ZERO_CHK_EN: a zero divisor short-cuts straight to DONE
// and raises div_by_zero_o; without it div_by_zero_o is tied low.

// Plain unsigned subtractor: diff = a - b, borrow set when b > a.
module subtractor_n #(
    parameter int unsigned width = 17
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic [width-1:0] diff_o,
    output logic             borrow_o
);

    logic [width:0] full;

    // Extend by one bit so the top bit of the result is the borrow.
    always_comb begin
        full     = {1'b0, a_i} - {1'b0, b_i};
        diff_o   = full[width-1:0];
        borrow_o = full[width];
    end

endmodule

module seq_divider_n #(
    parameter int unsigned nb_bit = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [nb_bit-1:0] dividend_i,
    input  logic [nb_bit-1:0] divisor_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [nb_bit-1:0] quotient_o,
    output logic [nb_bit-1:0] remainder_o,
    output logic              div_by_zero_o
);

    localparam int unsigned CNT_W = (nb_bit > 1) ? $clog2(nb_bit) : 1;
    localparam int unsigned SUB_W = nb_bit + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [nb_bit-1:0]  q_reg;
    logic [nb_bit-1:0]  d_reg;
    logic [nb_bit-1:0]  r_reg;
    logic [CNT_W-1:0]   cnt;

    logic [SUB_W-1:0]   sub_a;
    logic [SUB_W-1:0]   sub_b;
    logic [SUB_W-1:0]   sub_diff;
    logic               sub_borrow;
    logic [nb_bit-1:0]  q_next;
    logic [nb_bit-1:0]  r_next;
    logic               unused_diff_msb;

    subtractor_n #(.width(SUB_W)) u_sub (
        .a_i      (sub_a),
        .b_i      (sub_b),
        .diff_o   (sub_diff),
        .borrow_o (sub_borrow)
    );

    // One restoring step: trial-subtract D from the shifted partial remainder.
    always_comb begin
        sub_a  = {r_reg, q_reg[nb_bit-1]};
        sub_b  = {1'b0, d_reg};
        q_next = {q_reg[nb_bit-2:0], ~sub_borrow};
        // With R < D the successful difference is below D, so its MSB is always 0.
        r_next = sub_borrow ? {r_reg[nb_bit-2:0], q_reg[nb_bit-1]}
                            : sub_diff[nb_bit-1:0];
        unused_diff_msb = sub_diff[nb_bit];
    end

`ifndef DIV_ZERO_CHK_EN
    assign div_by_zero_o = 1'b0;
`endif

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ready_o     <= 1'b1;
            valid_o     <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
`ifdef DIV_ZERO_CHK_EN
            div_by_zero_o <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        q_reg   <= dividend_i;
                        d_reg   <= divisor_i;
                        r_reg   <= '0;
                        cnt     <= CNT_W'(nb_bit - 1);
                        ready_o <= 1'b0;
`ifdef DIV_ZERO_CHK_EN
                        if (divisor_i == '0) begin
                            state         <= DONE;
                            valid_o       <= 1'b1;
                            quotient_o    <= '1;
                            remainder_o   <= dividend_i;
                            div_by_zero_o <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    if (cnt == '0) begin
                        state       <= DONE;
                        valid_o     <= 1'b1;
                        quotient_o  <= q_next;
                        remainder_o <= r_next;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
`ifdef DIV_ZERO_CHK_EN
                        div_by_zero_o <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_n.sv
// tb_seq_divider_n: directed and small random checks of seq_divider_n at nb_bit=8 and 16.
module tb_seq_divider_n;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        valid_in8 = 1'b0, ready_in8 = 1'b0;
    logic [7:0]  dividend8 = '0, divisor8 = '0;
    logic        ready_out8, valid_out8, dbz8;
    logic [7:0]  quot8, rem8;

    logic        valid_in16 = 1'b0, ready_in16 = 1'b0;
    logic [15:0] dividend16 = '0, divisor16 = '0;
    logic        ready_out16, valid_out16, dbz16;
    logic [15:0] quot16, rem16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_divider_n #(.nb_bit(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_in8), .ready_o(ready_out8),
        .dividend_i(dividend8), .divisor_i(divisor8), .valid_o(valid_out8),
        .ready_i(ready_in8), .quotient_o(quot8), .remainder_o(rem8),
        .div_by_zero_o(dbz8)
    );

    seq_divider_n #(.nb_bit(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_in16), .ready_o(ready_out16),
        .dividend_i(dividend16), .divisor_i(divisor16), .valid_o(valid_out16),
        .ready_i(ready_in16), .quotient_o(quot16), .remainder_o(rem16),
        .div_by_zero_o(dbz16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_valid(input bit wide);
        return wide ? valid_out16 : valid_out8;
    endfunction

    function automatic logic get_ready(input bit wide);
        return wide ? ready_out16 : ready_out8;
    endfunction

    function automatic logic [31:0] get_q(input bit wide);
        return wide ? 32'(quot16) : 32'(quot8);
    endfunction

    function automatic logic [31:0] get_r(input bit wide);
        return wide ? 32'(rem16) : 32'(rem8);
    endfunction

    function automatic logic get_dbz(input bit wide);
        return wide ? dbz16 : dbz8;
    endfunction

    task automatic set_in(input bit wide, input logic v, input int unsigned a, input int unsigned b);
        if (wide) begin
            valid_in16 = v; dividend16 = 16'(a); divisor16 = 16'(b);
        end else begin
            valid_in8 = v; dividend8 = 8'(a); divisor8 = 8'(b);
        end
    endtask

    task automatic set_ready(input bit wide, input logic v);
        if (wide) ready_in16 = v; else ready_in8 = v;
    endtask

    // Issue one division, wait for the result, check it, leave the result in DONE.
    task automatic start_and_wait(input bit wide, input int unsigned a, input int unsigned b,
                                  input int unsigned exp_q, input int unsigned exp_r,
                                  input int unsigned exp_lat, input bit exp_dbz,
                                  input string tag);
        int unsigned lat;
        logic busy_ready;
        @(negedge clk);
        set_in(wide, 1'b1, a, b);
        @(negedge clk);
        set_in(wide, 1'b0, 0, 0);
        lat = 1;
        busy_ready = 1'b0;
        while (!get_valid(wide) && lat < 60) begin
            busy_ready |= get_ready(wide);
            @(negedge clk);
            lat++;
        end
        busy_ready |= get_ready(wide);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy_ready"}, 32'(busy_ready), 32'd0);
        check({tag, "_q"}, get_q(wide), exp_q);
        check({tag, "_r"}, get_r(wide), exp_r);
        check({tag, "_dbz"}, 32'(get_dbz(wide)), 32'(exp_dbz));
    endtask

    // Accept the pending result and confirm return to IDLE.
    task automatic release_result(input bit wide, input string tag);
        set_ready(wide, 1'b1);
        @(negedge clk);
        set_ready(wide, 1'b0);
        check({tag, "_idle_ready"}, 32'(get_ready(wide)), 32'd1);
        check({tag, "_idle_valid"}, 32'(get_valid(wide)), 32'd0);
        check({tag, "_idle_dbz"}, 32'(get_dbz(wide)), 32'd0);
    endtask

    task automatic do_div(input bit wide, input int unsigned a, input int unsigned b,
                          input int unsigned exp_q, input int unsigned exp_r,
                          input int unsigned exp_lat, input bit exp_dbz, input string tag);
        start_and_wait(wide, a, b, exp_q, exp_r, exp_lat, exp_dbz, tag);
        release_result(wide, tag);
    endtask

    initial begin
        int unsigned a, b;
        int unsigned zlat;
        bit zdbz;
`ifdef DIV_ZERO_CHK_EN
        zlat = 1;  zdbz = 1'b1;
`else
        zlat = 9;  zdbz = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready_out8), 32'd1);
        check("rst_valid", 32'(valid_out8), 32'd0);
        check("rst_q", 32'(quot8), 32'd0);
        check("rst_r", 32'(rem8), 32'd0);
        check("rst_dbz", 32'(dbz8), 32'd0);
        rst = 1'b0;

        do_div(1'b0, 200, 7, 28, 4, 9, 1'b0, "d200_7");
        do_div(1'b0, 5, 9, 0, 5, 9, 1'b0, "d5_9");
        do_div(1'b0, 255, 1, 255, 0, 9, 1'b0, "d255_1");
        do_div(1'b0, 255, 255, 1, 0, 9, 1'b0, "d255_255");
        do_div(1'b0, 100, 0, 255, 100, zlat, zdbz, "d100_0");
        do_div(1'b1, 100, 0, 65535, 100, (zdbz ? 1 : 17), zdbz, "w100_0");

        // Back-pressure: result held while new operands are offered.
        start_and_wait(1'b0, 200, 7, 28, 4, 9, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, i[0] ? 1'b0 : 1'b1, 17 + i, 3);
            @(negedge clk);
            check("bp_hold_valid", 32'(valid_out8), 32'd1);
            check("bp_hold_q", 32'(quot8), 32'd28);
            check("bp_hold_r", 32'(rem8), 32'd4);
            check("bp_hold_ready", 32'(ready_out8), 32'd0);
        end
        set_in(1'b0, 1'b0, 0, 0);
        release_result(1'b0, "bp");
        @(negedge clk);
        check("bp_no_capture", 32'(ready_out8), 32'd1);

        // Asynchronous reset in the middle of RUN cycle 4.
        @(negedge clk);
        set_in(1'b1, 1'b1, 1000, 3);
        @(negedge clk);
        set_in(1'b1, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 32'(ready_out16), 32'd1);
        check("arst_valid", 32'(valid_out16), 32'd0);
        check("arst_q", 32'(quot16), 32'd0);
        check("arst_r", 32'(rem16), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("arst_no_result", 32'(valid_out16), 32'd0);
        do_div(1'b1, 1000, 3, 333, 1, 17, 1'b0, "w1000_3");
        do_div(1'b1, 65535, 65535, 1, 0, 17, 1'b0, "w_max_max");
        do_div(1'b1, 40000, 7, 5714, 2, 17, 1'b0, "w40000_7");

        // Random sweep against integer division.
        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(255, 0);
            b = $urandom_range(255, 1);
            do_div(1'b0, a, b, a / b, a % b, 9, 1'b0, "rnd8");
        end
        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(65535, 0);
            b = (i < 10) ? $urandom_range(255, 1) : $urandom_range(65535, 1);
            do_div(1'b1, a, b, a / b, a % b, 17, 1'b0, "rnd16");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
